// File: rtl/control_fsm_mc.sv
// ============================================================================
// control_fsm_mc : multicycle main control FSM for the OCII datapath, with
//                  stall, handshaked multiply and sticky multiply timeout.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module control_fsm_mc #(
  parameter int OP_W      = 4,
  parameter int OP_JUMP   = 11,
  parameter int OP_BRANCH = 12,
  parameter int OP_MUL    = 15,
  parameter int IMM_MAX   = 5,
  parameter int MUL_TMO   = 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [OP_W-1:0] CodOP,
  input  logic            InstrValid,
  input  logic            Stall,
  input  logic            MulDone,
  output logic            EscLR,
  output logic            EscCP,
  output logic            EscCondCP,
  output logic            EscReg,
  output logic [1:0]      FonteCP,
  output logic [OP_W-1:0] ULA_OP,
  output logic            ULA_A,
  output logic [1:0]      ULA_B,
  output logic            MulStart,
  output logic            MulErr,
  output logic [2:0]      State
);

  localparam int CNT_W = $clog2(MUL_TMO);

  localparam logic [OP_W-1:0]  C_OP_JUMP   = OP_W'(OP_JUMP);
  localparam logic [OP_W-1:0]  C_OP_BRANCH = OP_W'(OP_BRANCH);
  localparam logic [OP_W-1:0]  C_OP_MUL    = OP_W'(OP_MUL);
  localparam logic [OP_W-1:0]  C_IMM_MAX   = OP_W'(IMM_MAX);
  localparam logic [CNT_W-1:0] C_TMO_LAST  = CNT_W'(MUL_TMO - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_PCINC  = 3'd3,
    S_JUMP   = 3'd4,
    S_BRANCH = 3'd5,
    S_MUL    = 3'd6,
    S_MULWB  = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (!Stall) begin
      case (state_q)
        S_FETCH: begin
          if (InstrValid) begin
            op_d    = CodOP;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          // counter is cleared here so every MUL entry starts at zero
          cnt_d = '0;
          if (op_q == C_OP_JUMP)        state_d = S_JUMP;
          else if (op_q == C_OP_BRANCH) state_d = S_BRANCH;
          else if (op_q == C_OP_MUL)    state_d = S_MUL;
          else                          state_d = S_EXEC;
        end
        S_EXEC:   state_d = S_PCINC;
        S_PCINC:  state_d = S_FETCH;
        S_JUMP:   state_d = S_FETCH;
        S_BRANCH: state_d = S_FETCH;
        S_MUL: begin
          // a late MulDone still wins over the timeout in the same cycle
          if (MulDone) begin
            state_d = S_MULWB;
          end else if (cnt_q == C_TMO_LAST) begin
            err_d   = 1'b1;
            state_d = S_PCINC;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_MULWB:  state_d = S_PCINC;
        default:  state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    EscLR     = 1'b0;
    EscCP     = 1'b0;
    EscCondCP = 1'b0;
    EscReg    = 1'b0;
    FonteCP   = 2'b00;
    ULA_OP    = '0;
    ULA_A     = 1'b0;
    ULA_B     = 2'b00;
    MulStart  = 1'b0;
    case (state_q)
      S_FETCH:  EscLR = 1'b1;
      S_DECODE: ULA_OP = op_q;
      S_EXEC: begin
        EscReg = 1'b1;
        ULA_A  = 1'b1;
        ULA_OP = op_q;
        ULA_B  = (op_q <= C_IMM_MAX) ? 2'b10 : 2'b01;
      end
      S_PCINC:  EscCP = 1'b1;
      S_JUMP: begin
        EscCP   = 1'b1;
        FonteCP = 2'b10;
      end
      S_BRANCH: begin
        EscCondCP = 1'b1;
        ULA_A     = 1'b1;
        ULA_B     = 2'b10;
        FonteCP   = 2'b01;
        ULA_OP    = op_q;
      end
      S_MUL: begin
        ULA_A    = 1'b1;
        ULA_B    = 2'b10;
        ULA_OP   = op_q;
        MulStart = (cnt_q == '0);
      end
      S_MULWB: begin
        EscReg = 1'b1;
        ULA_A  = 1'b1;
        ULA_B  = 2'b10;
        ULA_OP = op_q;
      end
      default: EscLR = 1'b1;
    endcase
    // a stall freezes side effects but leaves the datapath selects untouched
    if (Stall) begin
      EscLR     = 1'b0;
      EscCP     = 1'b0;
      EscCondCP = 1'b0;
      EscReg    = 1'b0;
      MulStart  = 1'b0;
    end
  end

  assign MulErr = err_q;
  assign State  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_control_fsm_mc.sv
// ============================================================================
// tb_control_fsm_mc : randomized instruction-level bench for control_fsm_mc
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_fsm_mc;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] CodOP;
  logic       InstrValid;
  logic       Stall;
  logic       MulDone;
  logic       EscLR, EscCP, EscCondCP, EscReg;
  logic [1:0] FonteCP;
  logic [3:0] ULA_OP;
  logic       ULA_A;
  logic [1:0] ULA_B;
  logic       MulStart;
  logic       MulErr;
  logic [2:0] State;

  int checks = 0;
  int errors = 0;
  logic err_exp;

  always #5 CLK = ~CLK;

  control_fsm_mc dut (
    .CLK(CLK), .RST_N(RST_N), .CodOP(CodOP), .InstrValid(InstrValid),
    .Stall(Stall), .MulDone(MulDone), .EscLR(EscLR), .EscCP(EscCP),
    .EscCondCP(EscCondCP), .EscReg(EscReg), .FonteCP(FonteCP),
    .ULA_OP(ULA_OP), .ULA_A(ULA_A), .ULA_B(ULA_B), .MulStart(MulStart),
    .MulErr(MulErr), .State(State)
  );

  wire [13:0] obs_out = {EscLR, EscCP, EscCondCP, EscReg, FonteCP, ULA_OP,
                         ULA_A, ULA_B, MulStart};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Spec output table per architectural state (0 FETCH .. 7 MULWB).
  function automatic logic [13:0] exp_out(input int st, input logic [3:0] op,
                                          input bit stall, input bit first);
    logic lr, cp, cond, rw, a, ms;
    logic [1:0] f, b;
    logic [3:0] u;
    {lr, cp, cond, rw, a, ms} = '0;
    f = 2'b00; b = 2'b00; u = 4'd0;
    case (st)
      0: lr = 1'b1;
      1: u = op;
      2: begin rw = 1'b1; a = 1'b1; u = op; b = (op <= 4'd5) ? 2'b10 : 2'b01; end
      3: cp = 1'b1;
      4: begin cp = 1'b1; f = 2'b10; end
      5: begin cond = 1'b1; a = 1'b1; b = 2'b10; f = 2'b01; u = op; end
      6: begin a = 1'b1; b = 2'b10; u = op; ms = first; end
      7: begin rw = 1'b1; a = 1'b1; b = 2'b10; u = op; end
      default: lr = 1'b1;
    endcase
    if (stall) {lr, cp, cond, rw, ms} = '0;
    return {lr, cp, cond, rw, f, u, a, b, ms};
  endfunction

  // One instruction: build the expected state trace, then walk it cycle by cycle.
  task automatic run_instr(input logic [3:0] op, input int fetch_wait, input int done_after,
                           input int stall_at, input int stall_len, input int abort_at);
    int sts[$];
    bit tmo;
    int n, mul_first, mul_last, pcw, msc, st;
    tmo = 0; mul_first = -1; mul_last = -1; pcw = 0; msc = 0;
    for (int i = 0; i <= fetch_wait; i++) sts.push_back(0);
    sts.push_back(1);
    if (op == 4'd11) sts.push_back(4);
    else if (op == 4'd12) sts.push_back(5);
    else if (op == 4'd15) begin
      tmo = (done_after >= 8);
      n = tmo ? 8 : done_after + 1;
      mul_first = sts.size();
      mul_last = mul_first + n - 1;
      for (int i = 0; i < n; i++) sts.push_back(6);
      if (!tmo) sts.push_back(7);
      sts.push_back(3);
    end else begin
      sts.push_back(2);
      sts.push_back(3);
    end

    for (int i = 0; i < sts.size(); i++) begin
      st = sts[i];
      if (i == stall_at) begin
        for (int k = 0; k < stall_len; k++) begin
          Stall = 1'b1;
          CodOP = 4'($urandom);
          InstrValid = 1'($urandom);
          MulDone = 1'($urandom);
          @(negedge CLK);
          check("stall_state", State, st);
          check("stall_out", obs_out, exp_out(st, op, 1'b1, 1'b0));
          check("stall_mulerr", MulErr, err_exp);
          @(posedge CLK); #1;
        end
      end
      Stall = 1'b0;
      CodOP = (i == fetch_wait) ? op : 4'($urandom);
      InstrValid = (st == 0) ? (i == fetch_wait) : 1'($urandom);
      MulDone = (st == 6) ? (i - mul_first == done_after) : 1'($urandom);
      @(negedge CLK);
      check("state", State, st);
      check("outputs", obs_out, exp_out(st, op, 1'b0, i == mul_first));
      check("mulerr", MulErr, err_exp);
      pcw += int'(EscCP) + int'(EscCondCP);
      msc += int'(MulStart);
      if (i == abort_at) begin
        #2 RST_N = 1'b0;
        #1;
        err_exp = 1'b0;
        check("abort_state", State, 0);
        check("abort_out", obs_out, exp_out(0, 4'd0, 1'b0, 1'b0));
        check("abort_mulerr", MulErr, err_exp);
        #1 RST_N = 1'b1;
        InstrValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(posedge CLK); #1;
          @(negedge CLK);
          check("idle_state", State, 0);
          check("idle_out", obs_out, exp_out(0, 4'd0, 1'b0, 1'b0));
        end
        @(posedge CLK); #1;
        return;
      end
      @(posedge CLK); #1;
      if (tmo && i == mul_last) err_exp = 1'b1;
    end
    check("pc_writes", pcw, 1);
    check("mulstart_pulses", msc, (op == 4'd15) ? 1 : 0);
  endtask

  initial begin
    logic [3:0] rop;
    int sa;
    RST_N = 1'b0; CodOP = 4'd0; InstrValid = 1'b0; Stall = 1'b0; MulDone = 1'b0;
    err_exp = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_state", State, 0);
    check("reset_out", obs_out, exp_out(0, 4'd0, 1'b0, 1'b0));
    check("reset_mulerr", MulErr, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;

    run_instr(4'b0011, 0, 0, -1, 0, -1);
    run_instr(4'b0111, 0, 0, -1, 0, -1);
    run_instr(4'b0101, 1, 0, -1, 0, -1);
    run_instr(4'b0110, 0, 0, -1, 0, -1);
    run_instr(4'b1011, 0, 0, -1, 0, -1);
    run_instr(4'b1100, 2, 0, -1, 0, -1);
    run_instr(4'b1111, 0, 3, -1, 0, -1);
    run_instr(4'b1111, 0, 7, -1, 0, -1);
    run_instr(4'b1111, 0, 20, -1, 0, -1);
    run_instr(4'b0011, 0, 0, -1, 0, -1);
    run_instr(4'b0001, 0, 0, 2, 3, -1);
    run_instr(4'b1111, 0, 2, 2, 3, -1);
    run_instr(4'b1111, 0, 4, 4, 3, -1);
    run_instr(4'b1111, 1, 20, -1, 0, 4);

    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0: rop = 4'd15;
        1: rop = ($urandom_range(0, 1) != 0) ? 4'd11 : 4'd12;
        default: rop = 4'($urandom);
      endcase
      sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8)) : -1;
      run_instr(rop, $urandom_range(0, 2), $urandom_range(0, 10), sa,
                $urandom_range(1, 3), ($urandom_range(0, 15) == 0) ? 3 : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
